// File: rtl/stack_unit.sv
// Parametrised LIFO for the datapath: encoded ops (PUSH/POP/REPLACE/DUP/SWAP/CLEAR),
// top/second operand taps, occupancy count and error reporting on rejected ops.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             err,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_REPLACE = 3'b011;
  localparam logic [2:0] OP_DUP     = 3'b100;
  localparam logic [2:0] OP_SWAP    = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;

  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0] CNT_TWO   = (AW+1)'(2);
  localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    idx_push;
  logic [AW-1:0]    idx_top;
  logic [AW-1:0]    idx_sec;
  logic [WIDTH-1:0] rd_top;
  logic [WIDTH-1:0] rd_sec;

  logic             we_a;
  logic [AW-1:0]    idx_a;
  logic [WIDTH-1:0] wd_a;
  logic             we_b;
  logic [AW-1:0]    idx_b;
  logic [WIDTH-1:0] wd_b;
  logic [AW:0]      count_nxt;
  logic             dout_we;
  logic             reject;
  logic             set_ovf;
  logic             set_udf;
  logic             clr_flags;

  // Indices wrap harmlessly when count is 0 or DEPTH: those reads are gated below
  // and no write is ever issued through a wrapped index.
  assign idx_push = AW'(count);
  assign idx_top  = AW'(count - CNT_ONE);
  assign idx_sec  = AW'(count - CNT_TWO);
  assign rd_top   = mem[idx_top];
  assign rd_sec   = mem[idx_sec];

  assign top    = (count != '0)      ? rd_top : '0;
  assign second = (count >= CNT_TWO) ? rd_sec : '0;
  assign full   = (count == CNT_DEPTH);
  assign empty  = (count == '0);

  always_comb begin
    we_a      = 1'b0;
    idx_a     = idx_push;
    wd_a      = data_in;
    we_b      = 1'b0;
    idx_b     = idx_sec;
    wd_b      = rd_top;
    count_nxt = count;
    dout_we   = 1'b0;
    reject    = 1'b0;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    clr_flags = 1'b0;
    case (op)
      OP_PUSH: begin
        if (!full) begin
          we_a      = 1'b1;
          count_nxt = count + CNT_ONE;
        end else begin
          reject  = 1'b1;
          set_ovf = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty) begin
          dout_we   = 1'b1;
          count_nxt = count - CNT_ONE;
        end else begin
          reject  = 1'b1;
          set_udf = 1'b1;
        end
      end
      OP_REPLACE: begin
        // An empty stack turns REPLACE into a plain PUSH.
        we_a = 1'b1;
        if (empty) begin
          count_nxt = count + CNT_ONE;
        end else begin
          idx_a   = idx_top;
          dout_we = 1'b1;
        end
      end
      OP_DUP: begin
        if (empty) begin
          reject  = 1'b1;
          set_udf = 1'b1;
        end else if (full) begin
          reject  = 1'b1;
          set_ovf = 1'b1;
        end else begin
          we_a      = 1'b1;
          wd_a      = rd_top;
          count_nxt = count + CNT_ONE;
        end
      end
      OP_SWAP: begin
        if (count < CNT_TWO) begin
          reject  = 1'b1;
          set_udf = 1'b1;
        end else begin
          we_a  = 1'b1;
          idx_a = idx_top;
          wd_a  = rd_sec;
          we_b  = 1'b1;
        end
      end
      OP_CLEAR: begin
        count_nxt = '0;
        clr_flags = 1'b1;
      end
      default: ;
    endcase
  end

  // Storage has no reset; the reset edge only suppresses writes.
  always_ff @(posedge clk) begin
    if (resetN) begin
      if (we_a) mem[idx_a] <= wd_a;
      if (we_b) mem[idx_b] <= wd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      count     <= '0;
      data_out  <= '0;
      err       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= count_nxt;
      err   <= reject;
      if (dout_we) data_out <= rd_top;
      overflow  <= !clr_flags && (overflow  || set_ovf);
      underflow <= !clr_flags && (underflow || set_udf);
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit (WIDTH=8, DEPTH=4): one task per scenario,
// each with its own inline comparisons against hand-computed values.
module tb_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_REPLACE = 3'b011;
  localparam logic [2:0] OP_DUP     = 3'b100;
  localparam logic [2:0] OP_SWAP    = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;

  logic             clk;
  logic             resetN;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] second;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             err;
  logic             overflow;
  logic             underflow;

  int n_checks;
  int n_fail;
  logic [WIDTH-1:0] exp_q[$];

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .op       (op),
    .data_in  (data_in),
    .data_out (data_out),
    .top      (top),
    .second   (second),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .err      (err),
    .overflow (overflow),
    .underflow(underflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one op for one edge, then return to NOP; sample #1 after the edge.
  task automatic drive_op(input logic [2:0] o, input logic [WIDTH-1:0] d);
    @(negedge clk);
    op      = o;
    data_in = d;
    @(posedge clk);
    #1;
    op      = OP_NOP;
    data_in = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    n_checks++; if (count !== 3'd0)      begin $display("FAIL reset_count actual=%0d expected=0", count); n_fail++; end
    n_checks++; if (empty !== 1'b1)      begin $display("FAIL reset_empty actual=%0b expected=1", empty); n_fail++; end
    n_checks++; if (full !== 1'b0)       begin $display("FAIL reset_full actual=%0b expected=0", full); n_fail++; end
    n_checks++; if (top !== 8'h00)       begin $display("FAIL reset_top actual=%0h expected=0", top); n_fail++; end
    n_checks++; if (data_out !== 8'h00)  begin $display("FAIL reset_data_out actual=%0h expected=0", data_out); n_fail++; end
    n_checks++; if ({err, overflow, underflow} !== 3'b000)
      begin $display("FAIL reset_flags actual=%b expected=000", {err, overflow, underflow}); n_fail++; end
  endtask

  task automatic test_push_overflow();
    logic [WIDTH-1:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive_op(OP_PUSH, vals[i]);
      exp_q.push_back(vals[i]);
      n_checks++; if (top !== vals[i]) begin $display("FAIL push_top[%0d] actual=%0h expected=%0h", i, top, vals[i]); n_fail++; end
    end
    n_checks++; if (count !== 3'd4)   begin $display("FAIL push_count actual=%0d expected=4", count); n_fail++; end
    n_checks++; if (full !== 1'b1)    begin $display("FAIL push_full actual=%0b expected=1", full); n_fail++; end
    n_checks++; if (empty !== 1'b0)   begin $display("FAIL push_empty actual=%0b expected=0", empty); n_fail++; end
    n_checks++; if (second !== 8'h33) begin $display("FAIL push_second actual=%0h expected=33", second); n_fail++; end
    n_checks++; if (err !== 1'b0)     begin $display("FAIL push_err_idle actual=%0b expected=0", err); n_fail++; end
    drive_op(OP_PUSH, 8'h55);
    n_checks++; if (err !== 1'b1)      begin $display("FAIL ovf_err actual=%0b expected=1", err); n_fail++; end
    n_checks++; if (overflow !== 1'b1) begin $display("FAIL ovf_flag actual=%0b expected=1", overflow); n_fail++; end
    n_checks++; if (count !== 3'd4)    begin $display("FAIL ovf_count actual=%0d expected=4", count); n_fail++; end
    n_checks++; if (top !== 8'h44)     begin $display("FAIL ovf_top actual=%0h expected=44", top); n_fail++; end
    drive_op(OP_NOP, 8'h00);
    n_checks++; if (err !== 1'b0)      begin $display("FAIL ovf_err_pulse actual=%0b expected=0", err); n_fail++; end
    n_checks++; if (overflow !== 1'b1) begin $display("FAIL ovf_sticky actual=%0b expected=1", overflow); n_fail++; end
  endtask

  task automatic test_pop_underflow();
    logic [WIDTH-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive_op(OP_POP, 8'h00);
      exp = exp_q.pop_back();
      n_checks++; if (data_out !== exp) begin $display("FAIL pop_data[%0d] actual=%0h expected=%0h", i, data_out, exp); n_fail++; end
    end
    n_checks++; if (empty !== 1'b1)  begin $display("FAIL pop_empty actual=%0b expected=1", empty); n_fail++; end
    n_checks++; if (count !== 3'd0)  begin $display("FAIL pop_count actual=%0d expected=0", count); n_fail++; end
    n_checks++; if (top !== 8'h00)   begin $display("FAIL pop_top actual=%0h expected=0", top); n_fail++; end
    drive_op(OP_POP, 8'h00);
    n_checks++; if (err !== 1'b1)       begin $display("FAIL udf_err actual=%0b expected=1", err); n_fail++; end
    n_checks++; if (underflow !== 1'b1) begin $display("FAIL udf_flag actual=%0b expected=1", underflow); n_fail++; end
    n_checks++; if (data_out !== 8'h11) begin $display("FAIL udf_data_hold actual=%0h expected=11", data_out); n_fail++; end
    n_checks++; if (count !== 3'd0)     begin $display("FAIL udf_count actual=%0d expected=0", count); n_fail++; end
  endtask

  task automatic test_replace();
    drive_op(OP_REPLACE, 8'hA0);
    n_checks++; if (count !== 3'd1)     begin $display("FAIL rep_empty_count actual=%0d expected=1", count); n_fail++; end
    n_checks++; if (top !== 8'hA0)      begin $display("FAIL rep_empty_top actual=%0h expected=a0", top); n_fail++; end
    n_checks++; if (data_out !== 8'h11) begin $display("FAIL rep_empty_data actual=%0h expected=11", data_out); n_fail++; end
    n_checks++; if (err !== 1'b0)       begin $display("FAIL rep_empty_err actual=%0b expected=0", err); n_fail++; end
    drive_op(OP_REPLACE, 8'hB0);
    n_checks++; if (data_out !== 8'hA0) begin $display("FAIL rep_data actual=%0h expected=a0", data_out); n_fail++; end
    n_checks++; if (top !== 8'hB0)      begin $display("FAIL rep_top actual=%0h expected=b0", top); n_fail++; end
    n_checks++; if (count !== 3'd1)     begin $display("FAIL rep_count actual=%0d expected=1", count); n_fail++; end
  endtask

  task automatic test_swap_dup();
    drive_op(OP_CLEAR, 8'h00);
    drive_op(OP_PUSH, 8'h01);
    drive_op(OP_PUSH, 8'h02);
    drive_op(OP_SWAP, 8'h00);
    n_checks++; if (top !== 8'h01)    begin $display("FAIL swap_top actual=%0h expected=01", top); n_fail++; end
    n_checks++; if (second !== 8'h02) begin $display("FAIL swap_second actual=%0h expected=02", second); n_fail++; end
    n_checks++; if (count !== 3'd2)   begin $display("FAIL swap_count actual=%0d expected=2", count); n_fail++; end
    drive_op(OP_DUP, 8'h00);
    n_checks++; if (count !== 3'd3)   begin $display("FAIL dup_count actual=%0d expected=3", count); n_fail++; end
    n_checks++; if (top !== 8'h01)    begin $display("FAIL dup_top actual=%0h expected=01", top); n_fail++; end
    n_checks++; if (second !== 8'h01) begin $display("FAIL dup_second actual=%0h expected=01", second); n_fail++; end
    drive_op(OP_CLEAR, 8'h00);
    drive_op(OP_PUSH, 8'hAA);
    drive_op(OP_SWAP, 8'h00);
    n_checks++; if (err !== 1'b1)       begin $display("FAIL swap_udf_err actual=%0b expected=1", err); n_fail++; end
    n_checks++; if (underflow !== 1'b1) begin $display("FAIL swap_udf_flag actual=%0b expected=1", underflow); n_fail++; end
    n_checks++; if (top !== 8'hAA)      begin $display("FAIL swap_udf_top actual=%0h expected=aa", top); n_fail++; end
    n_checks++; if (count !== 3'd1)     begin $display("FAIL swap_udf_count actual=%0d expected=1", count); n_fail++; end
  endtask

  task automatic test_clear_reset();
    for (int i = 0; i < 3; i++) drive_op(OP_PUSH, 8'hC0 + 8'(i));
    drive_op(OP_DUP, 8'h00);
    n_checks++; if (overflow !== 1'b1) begin $display("FAIL dup_ovf_flag actual=%0b expected=1", overflow); n_fail++; end
    n_checks++; if (err !== 1'b1)      begin $display("FAIL dup_ovf_err actual=%0b expected=1", err); n_fail++; end
    n_checks++; if (top !== 8'hC2)     begin $display("FAIL dup_ovf_top actual=%0h expected=c2", top); n_fail++; end
    drive_op(OP_CLEAR, 8'h00);
    n_checks++; if (count !== 3'd0)    begin $display("FAIL clr_count actual=%0d expected=0", count); n_fail++; end
    n_checks++; if ({overflow, underflow} !== 2'b00)
      begin $display("FAIL clr_flags actual=%b expected=00", {overflow, underflow}); n_fail++; end
    n_checks++; if (top !== 8'h00)     begin $display("FAIL clr_top actual=%0h expected=0", top); n_fail++; end
    n_checks++; if (err !== 1'b0)      begin $display("FAIL clr_err actual=%0b expected=0", err); n_fail++; end
    n_checks++; if (data_out !== 8'hA0) begin $display("FAIL clr_data_hold actual=%0h expected=a0", data_out); n_fail++; end
    drive_op(OP_PUSH, 8'h5A);
    @(negedge clk);
    resetN  = 1'b0;
    op      = OP_PUSH;
    data_in = 8'h77;
    @(posedge clk);
    #1;
    resetN  = 1'b1;
    op      = OP_NOP;
    data_in = '0;
    n_checks++; if (count !== 3'd0)     begin $display("FAIL rst_push_count actual=%0d expected=0", count); n_fail++; end
    n_checks++; if (data_out !== 8'h00) begin $display("FAIL rst_push_data actual=%0h expected=0", data_out); n_fail++; end
    n_checks++; if (top !== 8'h00)      begin $display("FAIL rst_push_top actual=%0h expected=0", top); n_fail++; end
    drive_op(OP_NOP, 8'h00);
    n_checks++; if (count !== 3'd0)     begin $display("FAIL rst_push_after actual=%0d expected=0", count); n_fail++; end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetN   = 1'b1;
    op       = OP_NOP;
    data_in  = '0;
    test_reset();
    test_push_overflow();
    test_pop_underflow();
    test_replace();
    test_swap_dup();
    test_clear_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Parametrised LIFO for the processor datapath; the next generation of the single-op push/pop stack.
- Generalised depth (full flag follows DEPTH) and an encoded operation port: PUSH, POP, REPLACE, DUP, SWAP, CLEAR.
- Exposes top and second-of-stack for operand fetch, an occupancy count, and error reporting on illegal operations.
- Sits between the instruction decoder and the ALU.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; any value >= 2, power of two not required.
- AW, $clog2(DEPTH), derived pointer width; count is AW+1 bits.

Ports:
- clk  input  1  rising-edge clock.
- resetN  input  1  reset, synchronous, active-low; priority over op.
- op  input  3  operation: 000 NOP, 001 PUSH, 010 POP, 011 REPLACE, 100 DUP, 101 SWAP, 110 CLEAR, 111 NOP.
- data_in  input  WIDTH  operand for PUSH/REPLACE.
- data_out  output  WIDTH  registered value removed by the last successful POP/REPLACE; holds otherwise.
- top  output  WIDTH  combinational mem[count-1]; 0 when count==0.
- second  output  WIDTH  combinational mem[count-2]; 0 when count<2.
- count  output  AW+1  current occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- err  output  1  one-cycle pulse the cycle after a rejected op.
- overflow  output  1  sticky: a PUSH/DUP was rejected because full.
- underflow  output  1  sticky: a POP/SWAP/DUP was rejected for lack of entries.

Behaviour:
- Reset (resetN==0 at posedge): count=0, data_out=0, err=0, overflow=0, underflow=0. Memory contents are not cleared; top/second read 0 via count gating.
- All state updates occur on posedge clk; an op takes effect in the same edge. top, second, count, full and empty reflect it from the next cycle.
- PUSH: legal if !full. mem[count]<=data_in; count+1.
- POP: legal if !empty. data_out<=mem[count-1]; count-1.
- REPLACE:
  - If !empty: data_out<=mem[count-1]; mem[count-1]<=data_in; count unchanged.
  - If empty: behaves as PUSH; data_out unchanged; not an error.
- DUP: legal if count>=1 and !full. mem[count]<=mem[count-1]; count+1.
  - count==0 is an underflow; full is an overflow. When both conditions could apply, underflow takes precedence; only one applies in practice.
- SWAP: legal if count>=2. Exchange mem[count-1] and mem[count-2]; count unchanged.
- CLEAR: count<=0; overflow and underflow cleared; data_out unchanged; never an error.
- NOP / 111: no state change.
- Rejected op:
  - No change to memory, count or data_out.
  - err=1 for exactly the following cycle; err=0 after any legal op or NOP.
  - Sets the relevant sticky flag, which stays set until reset or CLEAR.
- Boundaries:
  - count saturates neither above DEPTH nor below 0; illegal ops are the only path to those limits and are rejected.
  - full and empty are mutually exclusive for DEPTH >= 1.
- Reset mid-sequence: the op present on the reset edge is ignored.
- Memory holds no reset; implementation may use an inferred register array with one or two write ports. SWAP needs two writes in one cycle.

Test Plan:
- Bench uses WIDTH=8, DEPTH=4.
- Reset, then PUSH 0x11,0x22,0x33,0x44 -> count=4, full=1, top=0x44, second=0x33; a fifth PUSH 0x55 -> err pulse, overflow=1, count=4, top=0x44.
- From full: POP x4 -> data_out 0x44,0x33,0x22,0x11 in order, empty=1; a fifth POP -> err pulse, underflow=1, data_out holds 0x11.
- Empty REPLACE 0xA0 -> count=1, top=0xA0, data_out unchanged, err=0; then REPLACE 0xB0 -> data_out=0xA0, top=0xB0, count=1.
- PUSH 0x01, PUSH 0x02, SWAP -> top=0x01, second=0x02; DUP -> count=3, top=0x01; SWAP with count=1 (after CLEAR+PUSH) -> err, underflow=1.
- Set overflow, then CLEAR -> count=0, overflow=0, underflow=0, top=0; then resetN=0 asserted together with op=PUSH -> count=0, data_out=0, no push.
